// File: rtl/wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wb_arbiter_pkg
// Shared CPU constants for the writeback arbiter slice.
//   XLEN      : width of one register write
//   NREG      : number of architectural registers
//   AW        : register address width, log2(NREG)
//   port_e    : writeback port index (PORT_ALU = 0, PORT_LOAD = 1)
//   otherPort : returns the port that is not the argument
// ---------------------------------------------------------------------------
package wb_arbiter_pkg;

   localparam int XLEN = 4;
   localparam int NREG = 8;
   localparam int AW   = $clog2(NREG);

   // The two writeback sources. The round-robin pointer holds one of these.
   typedef enum logic {
      PORT_ALU  = 1'b0,
      PORT_LOAD = 1'b1
   } port_e;

   // After a port wins, priority passes to the other one.
   function automatic port_e otherPort(input port_e p);
      return (p == PORT_ALU) ? PORT_LOAD : PORT_ALU;
   endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Bundle of every bus signal around the writeback arbiter.
//   req0_*  : ALU writeback request (valid/rd/data in, ready out)
//   req1_*  : load-unit writeback request, same meaning as req0
//   alloc_* : issue stage reserving a destination register
//   we/rd_addr/rd_data : registered register-file write port
//   busy    : per-register pending-write scoreboard, bit 0 always 0
// Modports:
//   slave  : the arbiter itself
//   master : whatever drives the requests and watches the write port
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
   parameter int XLEN = wb_arbiter_pkg::XLEN,
   parameter int NREG = wb_arbiter_pkg::NREG,
   parameter int AW   = $clog2(NREG)
) ();

   logic            req0_valid;
   logic [AW-1:0]   req0_rd;
   logic [XLEN-1:0] req0_data;
   logic            req0_ready;

   logic            req1_valid;
   logic [AW-1:0]   req1_rd;
   logic [XLEN-1:0] req1_data;
   logic            req1_ready;

   logic            alloc_valid;
   logic [AW-1:0]   alloc_rd;

   logic            we;
   logic [AW-1:0]   rd_addr;
   logic [XLEN-1:0] rd_data;
   logic [NREG-1:0] busy;

   modport slave (
      input  req0_valid, req0_rd, req0_data,
      output req0_ready,
      input  req1_valid, req1_rd, req1_data,
      output req1_ready,
      input  alloc_valid, alloc_rd,
      output we, rd_addr, rd_data, busy
   );

   modport master (
      output req0_valid, req0_rd, req0_data,
      input  req0_ready,
      output req1_valid, req1_rd, req1_data,
      input  req1_ready,
      output alloc_valid, alloc_rd,
      input  we, rd_addr, rd_data, busy
   );

endinterface

// File: rtl/wb_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-request round-robin arbiter, purely combinational. The caller owns
// the pointer register; this block only decides and proposes the update.
//   req_i   : request vector, bit n = port n wants the bus
//   ptr_i   : current priority pointer (port that wins a tie)
//   gnt_o   : one-hot grant, all zero when nobody requests
//   ptr_d_o : pointer to load at the next edge
// ---------------------------------------------------------------------------
module rr_arb2
   import wb_arbiter_pkg::*;
(
   input  logic [1:0] req_i,
   input  port_e      ptr_i,
   output logic [1:0] gnt_o,
   output port_e      ptr_d_o
);

   // A lone requester always wins. On a tie the pointer decides. Whenever
   // anybody is granted, priority moves to the port that did not win; with
   // no grant the pointer is left where it was.
   always_comb begin
      gnt_o   = 2'b00;
      ptr_d_o = ptr_i;
      unique case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = (ptr_i == PORT_ALU) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
      if (gnt_o[0]) begin
         ptr_d_o = otherPort(PORT_ALU);
      end else if (gnt_o[1]) begin
         ptr_d_o = otherPort(PORT_LOAD);
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Merges the ALU and load-unit writeback streams into the single
// register-file write port and keeps the pending-write scoreboard.
//   clk : clock, everything updates on the rising edge
//   rst : synchronous active-high reset
//   bus : wb_arbiter_if slave side (requests, alloc, write port, busy)
// Writes appear on we/rd_addr/rd_data one cycle after their handshake.
// A write to x0 is accepted but never raises we.
// ---------------------------------------------------------------------------
module wb_arbiter
   import wb_arbiter_pkg::*;
#(
   parameter int XLEN = wb_arbiter_pkg::XLEN,
   parameter int NREG = wb_arbiter_pkg::NREG
) (
   input  logic clk,
   input  logic rst,
   wb_arbiter_if.slave bus
);

   localparam int RAW = $clog2(NREG);

   logic [1:0]      reqValid;
   logic [1:0]      gnt;
   logic            handshake;
   logic [RAW-1:0]  selRd;
   logic [XLEN-1:0] selData;

   port_e           rr_q;
   port_e           rr_d;

   logic            we_q;
   logic            we_d;
   logic [RAW-1:0]  addr_q;
   logic [RAW-1:0]  addr_d;
   logic [XLEN-1:0] data_q;
   logic [XLEN-1:0] data_d;
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // Requests are hidden from the arbiter during reset so neither port
   // sees ready and nothing can be accepted while the block is clearing.
   always_comb begin
      reqValid = {bus.req1_valid, bus.req0_valid} & {2{~rst}};
   end

   rr_arb2 u_arb (
      .req_i   (reqValid),
      .ptr_i   (rr_q),
      .gnt_o   (gnt),
      .ptr_d_o (rr_d)
   );

   assign bus.req0_ready = gnt[0];
   assign bus.req1_ready = gnt[1];

   // Pick the winning request and work out what the write port registers
   // will hold next cycle. Without a handshake the address and data just
   // hold; we only goes high for a winner that targets a real register.
   always_comb begin
      handshake = |gnt;
      selRd     = gnt[1] ? bus.req1_rd   : bus.req0_rd;
      selData   = gnt[1] ? bus.req1_data : bus.req0_data;
      we_d      = handshake && (selRd != '0);
      addr_d    = handshake ? selRd   : addr_q;
      data_d    = handshake ? selData : data_q;
   end

   // Scoreboard next state. The clear for the write currently on the port
   // is applied first and the alloc set second, so a same-cycle set and
   // clear of one register leaves it busy. x0 can never become busy.
   always_comb begin
      busy_d = busy_q;
      if (we_q) begin
         busy_d[addr_q] = 1'b0;
      end
      if (bus.alloc_valid && (bus.alloc_rd != '0)) begin
         busy_d[bus.alloc_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // All state in one place: pointer, write port and scoreboard. Reset
   // wins over any alloc or writeback arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q   <= PORT_ALU;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         rr_q   <= rr_d;
         we_q   <= we_d;
         addr_q <= addr_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   // While reset is held the visible outputs read as zero straight away,
   // so a write captured just before reset rose never pulses we.
   always_comb begin
      bus.we      = we_q & ~rst;
      bus.rd_addr = rst ? '0 : addr_q;
      bus.rd_data = rst ? '0 : data_q;
      bus.busy    = rst ? '0 : busy_q;
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Directed scenarios followed by a random run, every cycle compared with a
// behavioural model of the writeback arbiter kept in this bench.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

   localparam int XLEN = wb_arbiter_pkg::XLEN;
   localparam int NREG = wb_arbiter_pkg::NREG;
   localparam int AW   = wb_arbiter_pkg::AW;

   logic clk;
   logic rst;

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;
   int cycleNo    = 0;

   // Reference model state: who has priority on a tie, which registers are
   // reserved, and what the write port should be showing this cycle.
   int        prioPort = 0;
   bit [7:0]  busyModel = 8'h00;
   bit        weModel = 1'b0;
   int        addrModel = 0;
   int        dataModel = 0;

   wb_arbiter_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

   wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h",
                tag, cycleNo, observed, expected);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, compare what the
   // DUT shows against the model, then advance the model to what the next
   // rising edge should produce.
   task automatic applyStimulus(input bit r,
                                input bit v0, input int rd0, input int d0,
                                input bit v1, input int rd1, input int d1,
                                input bit av, input int ard);
      int grant;
      int wRd;
      int wData;
      @(negedge clk);
      cycleNo++;
      rst             = r;
      bus.req0_valid  = v0;
      bus.req0_rd     = rd0[AW-1:0];
      bus.req0_data   = d0[XLEN-1:0];
      bus.req1_valid  = v1;
      bus.req1_rd     = rd1[AW-1:0];
      bus.req1_data   = d1[XLEN-1:0];
      bus.alloc_valid = av;
      bus.alloc_rd    = ard[AW-1:0];
      #1;

      grant = -1;
      if (!r) begin
         if (v0 && v1) grant = prioPort;
         else if (v0)  grant = 0;
         else if (v1)  grant = 1;
      end

      checkOutput("req0_ready", {31'd0, bus.req0_ready}, {31'd0, grant == 0});
      checkOutput("req1_ready", {31'd0, bus.req1_ready}, {31'd0, grant == 1});
      checkOutput("we",      {31'd0, bus.we},    r ? 32'd0 : {31'd0, weModel});
      checkOutput("rd_addr", 32'(bus.rd_addr),   r ? 32'd0 : 32'(addrModel));
      checkOutput("rd_data", 32'(bus.rd_data),   r ? 32'd0 : 32'(dataModel));
      checkOutput("busy",    32'(bus.busy),      r ? 32'd0 : 32'(busyModel));

      if (r) begin
         prioPort  = 0;
         busyModel = 8'h00;
         weModel   = 1'b0;
         addrModel = 0;
         dataModel = 0;
      end else begin
         if (weModel) busyModel[addrModel] = 1'b0;
         if (av && ard != 0) busyModel[ard] = 1'b1;
         if (grant >= 0) begin
            wRd       = (grant == 1) ? rd1 : rd0;
            wData     = (grant == 1) ? d1  : d0;
            weModel   = (wRd != 0);
            addrModel = wRd;
            dataModel = wData;
            prioPort  = 1 - grant;
         end else begin
            weModel = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic doReset(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1, 1, 3, 5, 1, 4, 6, 1, 2);
   endtask

   initial begin
      rst             = 1'b1;
      bus.req0_valid  = 1'b0;
      bus.req0_rd     = '0;
      bus.req0_data   = '0;
      bus.req1_valid  = 1'b0;
      bus.req1_rd     = '0;
      bus.req1_data   = '0;
      bus.alloc_valid = 1'b0;
      bus.alloc_rd    = '0;

      $display("[TB] reset with requests held high, then idle");
      doReset(3);
      idle(2);

      $display("[TB] single ALU write to x3");
      applyStimulus(0, 1, 3, 'hA, 0, 0, 0, 0, 0);
      idle(2);

      $display("[TB] both ports valid for four cycles from reset");
      doReset(1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, 'h1, 1, 2, 'h2, 0, 0);
      idle(2);

      $display("[TB] alloc x5 then load write to x5");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5);
      idle(2);
      applyStimulus(0, 0, 0, 0, 1, 5, 'h7, 0, 0);
      idle(3);

      $display("[TB] alloc x4 colliding with write to x4, alloc x0");
      applyStimulus(0, 1, 4, 'h3, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4);
      idle(2);

      $display("[TB] write to x0 and reset right after a handshake");
      applyStimulus(0, 0, 0, 0, 1, 0, 'h9, 0, 0);
      idle(1);
      applyStimulus(0, 1, 6, 'hC, 0, 0, 0, 1, 6);
      doReset(1);
      idle(2);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 29) == 0),
                       1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       $urandom_range(0, 15),
                       1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       $urandom_range(0, 15),
                       ($urandom_range(0, 2) == 0), $urandom_range(0, 7));
      end
      idle(2);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
